uart_tx_buffered: RTL and testbench

Buffered UART transmitter for the command/status return path. Firmware-side logic pushes bytes through a valid/ready interface into an internal FIFO. The block serialises the bytes onto uart_tx as 8N1 frames, LSB first. It complements the command receiver and lets the control logic queue multi-byte replies without tracking per-frame timing.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_buffered_if.sv | 9 +
 rtl/sync_fifo_byte.sv | 43 ++++
 rtl/uart_tx_buffered.sv | 93 +++++++++
 tb/tb_uart_tx_buffered.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame constants and divider helper
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS = 8;
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: valid/ready byte push interface into the transmitter
interface uart_tx_buffered_if;
    import uart_pkg::*;
    logic [DATA_BITS-1:0] data_in;
    logic data_in_valid;
    logic data_in_ready;
    modport master (output data_in, data_in_valid, input data_in_ready);
    modport slave (input data_in, data_in_valid, output data_in_ready);
endinterface

// File: rtl/sync_fifo_byte.sv
// sync_fifo_byte: single-clock byte FIFO, registered read data on pop
module sync_fifo_byte #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;

    assign level = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = level == (AW + 1)'(DEPTH);
    assign push_ok = push && !full;
    assign pop_ok = pop && !empty;

    // storage array, written on accepted pushes only
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;

    // pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout <= mem[rd_ptr[AW-1:0]];
            end
        end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed 8N1 serial transmitter, LSB first
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_buffered_if.slave             in_if,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);

    tx_state_t state, state_nx;
    logic [CW-1:0] baud_cnt;
    logic [BW-1:0] bit_idx;
    logic [DATA_BITS-1:0] shift, fifo_dout;
    logic fifo_full, fifo_empty, push, pop, baud_end, last_bit, tx_nx;

    assign in_if.data_in_ready = !fifo_full;
    assign push = in_if.data_in_valid && in_if.data_in_ready;
    assign baud_end = baud_cnt == CW'(BAUD_DIV - 1);
    assign last_bit = bit_idx == BW'(DATA_BITS - 1);

    sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_if.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // next state: stop bit chains straight into the next start when data waits
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = fifo_empty ? IDLE : START;
            START: state_nx = baud_end ? DATA : START;
            DATA:  state_nx = (baud_end && last_bit) ? STOP : DATA;
            STOP:  state_nx = !baud_end ? STOP : (fifo_empty ? IDLE : START);
            default: state_nx = IDLE;
        endcase
    end

    // outputs: FIFO pop request and next line level
    always_comb begin
        pop = !fifo_empty && (state == IDLE || (state == STOP && baud_end));
        tx_nx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end

    // baud counter, bit index and shift register; the popped byte is
    // latched from the FIFO read register at the end of the start bit
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            baud_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
        end else begin
            baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
            if (state == START && baud_end) begin
                bit_idx <= '0;
                shift <= fifo_dout;
            end else if (state == DATA && baud_end) begin
                bit_idx <= bit_idx + 1'b1;
                shift <= shift >> 1;
            end
        end

    // registered line and busy flag, both lag the FSM by one cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            uart_tx <= tx_nx;
            tx_busy <= state != IDLE || !fifo_empty;
        end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed scoreboard bench for the buffered UART transmitter
module tb_uart_tx_buffered;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx, tx_busy;
    logic [LW-1:0] fifo_level;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int frames = 0;
    logic [7:0] exp_q[$];

    uart_tx_buffered_if bus();

    uart_tx_buffered #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d, input bit acc);
        check("ready_before_push", bus.data_in_ready, acc);
        bus.data_in = d;
        bus.data_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic at_edge(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // line decoder: samples mid-bit, pops the scoreboard per frame
    initial begin : mon
        bit m_act;
        int m_cnt;
        logic [7:0] m_byte;
        m_act = 1'b0;
        m_cnt = 0;
        m_byte = '0;
        forever begin
            @(negedge clk);
            if (rst) m_act = 1'b0;
            else if (!m_act) begin
                if (uart_tx === 1'b0) begin
                    m_act = 1'b1;
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 5) check("start_bit", uart_tx, 0);
                else if (m_cnt >= 15 && m_cnt <= 85 && m_cnt % 10 == 5) m_byte[(m_cnt - 15) / 10] = uart_tx;
                else if (m_cnt == 95) begin
                    check("stop_bit", uart_tx, 1);
                    frames++;
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("frame_byte", m_byte, exp_q.pop_front());
                end else if (m_cnt == 99) m_act = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, k;
        bus.data_in = '0;
        bus.data_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset", {uart_tx, bus.data_in_ready, tx_busy, fifo_level}, 32'hC0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle", {uart_tx, bus.data_in_ready, tx_busy, fifo_level}, 32'hC0);
        end

        // single byte latency and frame length
        f0 = frames;
        push(8'hA5, 1);
        n = cyc;
        check("a5_level_n", fifo_level, 1);
        check("a5_busy_n", tx_busy, 0);
        check("a5_tx_n", uart_tx, 1);
        at_edge(n + 1);
        check("a5_level_n1", fifo_level, 0);
        check("a5_busy_n1", tx_busy, 1);
        check("a5_tx_n1", uart_tx, 1);
        at_edge(n + 2);
        check("a5_tx_fall", uart_tx, 0);
        at_edge(n + 11);
        check("a5_start_end", uart_tx, 0);
        at_edge(n + 12);
        check("a5_bit0", uart_tx, 1);
        at_edge(n + 101);
        check("a5_busy_n101", tx_busy, 1);
        at_edge(n + 102);
        check("a5_busy_n102", tx_busy, 0);
        check("a5_tx_idle", uart_tx, 1);
        check("a5_frames", frames, f0 + 1);
        check("a5_sb_empty", exp_q.size(), 0);

        // back-to-back frames with no idle gap
        f0 = frames;
        push(8'h55, 1);
        n = cyc;
        push(8'h0F, 1);
        check("b2b_level", fifo_level, 1);
        at_edge(n + 101);
        check("b2b_last_stop", uart_tx, 1);
        at_edge(n + 102);
        check("b2b_second_start", uart_tx, 0);
        at_edge(n + 201);
        check("b2b_busy_n201", tx_busy, 1);
        at_edge(n + 202);
        check("b2b_busy_n202", tx_busy, 0);
        check("b2b_frames", frames, f0 + 2);

        // fill the FIFO while the first byte is in flight
        f0 = frames;
        n = cyc + 1;
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), 1);
        check("fill_level", fifo_level, 16);
        check("fill_ready", bus.data_in_ready, 0);
        push(8'h99, 0);
        check("fill_refused_level", fifo_level, 16);

        // push on a pop edge while full is refused
        at_edge(n + 100);
        check("full_pre_pop_level", fifo_level, 16);
        bus.data_in = 8'hEE;
        bus.data_in_valid = 1'b1;
        at_edge(n + 101);
        bus.data_in_valid = 1'b0;
        check("full_pop_level", fifo_level, 15);
        check("full_pop_ready", bus.data_in_ready, 1);

        // push on a pop edge while not full keeps the level
        at_edge(n + 200);
        check("np_pre_level", fifo_level, 15);
        bus.data_in = 8'h3C;
        bus.data_in_valid = 1'b1;
        exp_q.push_back(8'h3C);
        at_edge(n + 201);
        bus.data_in_valid = 1'b0;
        check("np_level", fifo_level, 15);
        k = 0;
        while (tx_busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_busy", tx_busy, 0);
        check("drain_sb_empty", exp_q.size(), 0);
        check("drain_frames", frames, f0 + 18);

        // asynchronous reset during bit 3 with bytes queued
        push(8'hF0, 1);
        n = cyc;
        push(8'h11, 1);
        push(8'h22, 1);
        push(8'h33, 1);
        push(8'h44, 1);
        check("rst_queued", fifo_level, 4);
        at_edge(n + 45);
        check("rst_bit3_low", uart_tx, 0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_tx", uart_tx, 1);
        check("rst_level", fifo_level, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_ready", bus.data_in_ready, 1);
        f0 = frames;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("post_rst_idle", {uart_tx, tx_busy, fifo_level}, 32'h40);
        end
        check("post_rst_frames", frames, f0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
